// File: rtl/qei_multi_counter.sv
// Quadrature encoder interface: synchronized, glitch-filtered A/B/Z decoding into a position count.
// Define QEI_VELOCITY_EN to build the windowed velocity measurement; otherwise vel/vel_valid read 0.
module qei_multi_counter #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4,
  parameter int VEL_WIN     = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             z_in,
  input  logic             idx_clr_en,
  input  logic             err_clr,
  output logic [CNT_W-1:0] count,
  output logic             dir,
  output logic             step,
  output logic             idx_pulse,
  output logic             err,
  output logic [CNT_W-1:0] vel,
  output logic             vel_valid
);

  localparam int FW     = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam int SETTLE = SYNC_STAGES + FILT_LEN + 1;
  localparam int SW     = $clog2(SETTLE + 1);

  if (CNT_W < 8 || CNT_W > 32) begin : g_bad_cnt_w
    $error("CNT_W out of range");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("SYNC_STAGES out of range");
  end
  if (FILT_LEN < 1 || FILT_LEN > 16) begin : g_bad_filt
    $error("FILT_LEN out of range");
  end
  if (VEL_WIN < 2 || VEL_WIN > 65535) begin : g_bad_win
    $error("VEL_WIN out of range");
  end

  // Pin bundle ordering everywhere below: {A, B, Z}
  logic [SYNC_STAGES-1:0][2:0] sync_pipe;
  logic [2:0]                  synced;
  logic [2:0]                  filt;
  logic [FW-1:0]               filt_cnt [3];
  logic [SW-1:0]               settle_cnt;
  logic                        settled;
  logic [1:0]                  cur_ab, prev_ab, ab_diff;
  logic                        cur_z, prev_z;
  logic                        legal, illegal, fwd, z_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_pipe <= '0;
    end else begin
      sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], {a_in, b_in, z_in}};
    end
  end

  assign synced = sync_pipe[SYNC_STAGES-1];

  // A level is accepted on the FILT_LEN-th consecutive cycle it disagrees with the filtered value
  always_ff @(posedge clk) begin
    if (rst) begin
      filt <= '0;
      for (int i = 0; i < 3; i++) filt_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (synced[i] == filt[i]) begin
          filt_cnt[i] <= '0;
        end else if (filt_cnt[i] == FW'(FILT_LEN - 1)) begin
          filt[i]     <= synced[i];
          filt_cnt[i] <= '0;
        end else begin
          filt_cnt[i] <= filt_cnt[i] + FW'(1);
        end
      end
    end
  end

  // Until the pipeline has refilled after reset, filtered levels only seed the decoder baseline
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= '0;
    end else if (!settled) begin
      settle_cnt <= settle_cnt + SW'(1);
    end
  end

  assign settled = (settle_cnt == SW'(SETTLE));
  assign cur_ab  = filt[2:1];
  assign cur_z   = filt[0];

  always_comb begin
    ab_diff = cur_ab ^ prev_ab;
    legal   = settled && (ab_diff == 2'b01 || ab_diff == 2'b10);
    illegal = settled && (ab_diff == 2'b11);
    fwd     = prev_ab[1] ^ cur_ab[0];
    z_rise  = settled && cur_z && !prev_z;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_ab   <= '0;
      prev_z    <= 1'b0;
      count     <= '0;
      dir       <= 1'b0;
      step      <= 1'b0;
      idx_pulse <= 1'b0;
      err       <= 1'b0;
    end else begin
      prev_ab   <= cur_ab;
      prev_z    <= cur_z;
      step      <= legal;
      idx_pulse <= z_rise;
      err       <= illegal | (err & ~err_clr);
      if (legal) dir <= fwd;
      if (z_rise && idx_clr_en) begin
        count <= '0;
      end else if (legal) begin
        count <= fwd ? count + CNT_W'(1) : count - CNT_W'(1);
      end
    end
  end

`ifdef QEI_VELOCITY_EN
  localparam int WW = $clog2(VEL_WIN);

  logic [WW-1:0]    win_cnt;
  logic [CNT_W-1:0] vel_acc;
  logic [CNT_W-1:0] step_delta;

  always_comb begin
    step_delta = '0;
    if (legal) step_delta = fwd ? CNT_W'(1) : '1;
  end

  // A step on the closing cycle belongs to the next window
  always_ff @(posedge clk) begin
    if (rst) begin
      win_cnt   <= '0;
      vel_acc   <= '0;
      vel       <= '0;
      vel_valid <= 1'b0;
    end else if (win_cnt == WW'(VEL_WIN - 1)) begin
      win_cnt   <= '0;
      vel       <= vel_acc;
      vel_valid <= 1'b1;
      vel_acc   <= step_delta;
    end else begin
      win_cnt   <= win_cnt + WW'(1);
      vel_acc   <= vel_acc + step_delta;
      vel_valid <= 1'b0;
    end
  end
`else
  assign vel       = '0;
  assign vel_valid = 1'b0;
`endif

endmodule

// File: tb/tb_qei_multi_counter.sv
// Randomized self-checking bench for qei_multi_counter against a transition-level encoder model.
// Compile with QEI_VELOCITY_EN to also check the per-window velocity reports.
module tb_qei_multi_counter;

  localparam int CNT_W       = 16;
  localparam int SYNC_STAGES = 2;
  localparam int FILT_LEN    = 4;
  localparam int VEL_WIN     = 256;
  localparam int LAT         = SYNC_STAGES + FILT_LEN + 1;

  logic             clk = 1'b0;
  logic             rst, a_in, b_in, z_in, idx_clr_en, err_clr;
  logic [CNT_W-1:0] count, vel;
  logic             dir, step, idx_pulse, err, vel_valid;

  qei_multi_counter #(
    .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN), .VEL_WIN(VEL_WIN)
  ) dut (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .z_in(z_in),
    .idx_clr_en(idx_clr_en), .err_clr(err_clr), .count(count), .dir(dir),
    .step(step), .idx_pulse(idx_pulse), .err(err), .vel(vel), .vel_valid(vel_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: quadrature position of the accepted pin state, plus expected outputs
  logic [1:0]       m_ab;
  logic             m_z, m_dir, m_err;
  logic [CNT_W-1:0] m_count;
  int               m_steps = 0, m_idx = 0;
  int               win_sum [int];
  int               vel_log [int];
  int               edge_num = 0, step_seen = 0, idx_seen = 0, vv_seen = 0;
  int               mon_k, mon_exp;
  logic [CNT_W-1:0] mon_ev;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at edge %0d", tag, got, exp, edge_num);
    end
  endtask

  function automatic int pos_of(input logic [1:0] ab);
    case (ab)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] ab_of(input int p);
    case (p & 3)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) edge_num = 0;
    else     edge_num = edge_num + 1;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (step === 1'b1)      step_seen++;
      if (idx_pulse === 1'b1) idx_seen++;
      if (vel_valid === 1'b1) begin
        vv_seen++;
`ifdef QEI_VELOCITY_EN
        mon_k   = edge_num / VEL_WIN - 1;
        mon_exp = win_sum.exists(mon_k) ? win_sum[mon_k] : 0;
        mon_ev  = mon_exp[CNT_W-1:0];
        checkOutput("vel_window", 32'(vel), 32'(mon_ev));
        checkOutput("vel_phase", edge_num % VEL_WIN, 0);
        vel_log[mon_k] = int'(vel);
`endif
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Predicts the effect of moving the pins to a new steady state, decoded LAT edges from now
  task automatic model_move(input logic [1:0] new_ab, input logic new_z);
    int d, w;
    d = (pos_of(new_ab) - pos_of(m_ab)) & 3;
    w = (edge_num + LAT) / VEL_WIN;
    if (d == 1 || d == 3) begin
      m_count = (d == 1) ? m_count + 1'b1 : m_count - 1'b1;
      m_dir   = (d == 1);
      m_steps++;
      if (!win_sum.exists(w)) win_sum[w] = 0;
      win_sum[w] = win_sum[w] + ((d == 1) ? 1 : -1);
    end else if (d == 2) begin
      m_err = 1'b1;
    end
    if (new_z && !m_z) begin
      m_idx++;
      if (idx_clr_en) m_count = '0;
    end
    m_ab = new_ab;
    m_z  = new_z;
  endtask

  task automatic applyStimulus(input logic a, input logic b, input logic z, input int hold);
    model_move({a, b}, z);
    a_in = a;
    b_in = b;
    z_in = z;
    repeat (hold) tick();
  endtask

  task automatic step_by(input int dirn, input int hold);
    logic [1:0] ab;
    ab = ab_of(pos_of(m_ab) + dirn);
    applyStimulus(ab[1], ab[0], m_z, hold);
  endtask

  task automatic check_state(input string tag);
    checkOutput({tag, "_count"}, 32'(count), 32'(m_count));
    checkOutput({tag, "_dir"}, 32'(dir), 32'(m_dir));
    checkOutput({tag, "_err"}, 32'(err), 32'(m_err));
  endtask

  // Pins stay where they are; their current level becomes the new baseline
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    checkOutput("rst_count", 32'(count), 0);
    checkOutput("rst_dir", 32'(dir), 0);
    checkOutput("rst_step", 32'(step), 0);
    checkOutput("rst_idx", 32'(idx_pulse), 0);
    checkOutput("rst_err", 32'(err), 0);
    checkOutput("rst_vel", 32'(vel), 0);
    checkOutput("rst_vv", 32'(vel_valid), 0);
    rst     = 1'b0;
    m_count = '0;
    m_dir   = 1'b0;
    m_err   = 1'b0;
    m_ab    = {a_in, b_in};
    m_z     = z_in;
    win_sum.delete();
    vel_log.delete();
    vv_seen = 0;
    repeat (12) tick();
  endtask

  task automatic goto_0123();
    if (z_in) applyStimulus(m_ab[1], m_ab[0], 1'b0, 12);
    do_reset();
    for (int i = 0; i < 291; i++) step_by(1, 5);
    repeat (10) tick();
    checkOutput("goto_0123", 32'(count), 32'h0123);
  endtask

  initial begin
    int lat, s0, i0, r, hold, len;
    logic [CNT_W-1:0] c0;
    logic [1:0] ab;
    logic nz;

    rst = 1'b1; a_in = 0; b_in = 0; z_in = 0; idx_clr_en = 0; err_clr = 0;
    m_ab = 2'b00; m_z = 0; m_count = '0; m_dir = 0; m_err = 0;
    repeat (3) tick();
    do_reset();

    // Forward cycle 00->01->11->10->00
    s0 = step_seen;
    for (int i = 0; i < 4; i++) begin
      step_by(1, 16);
      check_state("fwd");
    end
    checkOutput("fwd_total", 32'(count), 4);
    checkOutput("fwd_steps", step_seen - s0, 4);

    // Reverse cycle, then wrap below zero and back up
    for (int i = 0; i < 4; i++) begin
      step_by(-1, 16);
      check_state("bwd");
    end
    step_by(-1, 16);
    checkOutput("wrap_down", 32'(count), 32'hFFFF);
    checkOutput("wrap_dir", 32'(dir), 0);
    step_by(1, 16);
    checkOutput("wrap_up", 32'(count), 0);

    // Short A pulse from state 01 is rejected; a held one counts after LAT cycles
    applyStimulus(1'b0, 1'b1, 1'b0, 16);
    c0 = count;
    s0 = step_seen;
    a_in = 1'b1;
    repeat (FILT_LEN - 1) tick();
    a_in = 1'b0;
    repeat (12) tick();
    checkOutput("glitch_count", 32'(count), 32'(c0));
    checkOutput("glitch_steps", step_seen - s0, 0);
    model_move(2'b11, 1'b0);
    a_in = 1'b1;
    lat  = 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (count !== c0) begin
        lat = k;
        break;
      end
    end
    checkOutput("latency", lat, LAT);
    repeat (8) tick();
    check_state("lat");
    checkOutput("lat_steps", step_seen - s0, 1);

    // Illegal double change, sticky error, clear, and clear losing to a new error
    s0 = step_seen;
    applyStimulus(1'b0, 1'b0, 1'b0, 16);
    check_state("illegal");
    checkOutput("illegal_steps", step_seen - s0, 0);
    err_clr = 1'b1; tick(); err_clr = 1'b0; m_err = 1'b0;
    checkOutput("err_clr", 32'(err), 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 16);
    check_state("illegal2");
    model_move(2'b00, 1'b0);
    a_in = 1'b0; b_in = 1'b0;
    repeat (LAT - 1) tick();
    err_clr = 1'b1; tick(); err_clr = 1'b0;
    checkOutput("err_clr_vs_new", 32'(err), 1);
    repeat (8) tick();
    step_by(1, 16);
    check_state("after_illegal");

    // Index pulse coinciding with a forward step, with and without clearing
    for (int clr = 1; clr >= 0; clr--) begin
      goto_0123();
      i0 = idx_seen;
      idx_clr_en = clr[0];
      ab = ab_of(pos_of(m_ab) + 1);
      applyStimulus(ab[1], ab[0], 1'b1, 16);
      checkOutput("idx_count", 32'(count), clr ? 0 : 32'h0124);
      checkOutput("idx_dir", 32'(dir), 1);
      checkOutput("idx_pulses", idx_seen - i0, 1);
      idx_clr_en = 1'b0;
      applyStimulus(ab[1], ab[0], 1'b0, 16);
      checkOutput("idx_fall", idx_seen - i0, 1);
    end

    // Reset mid-filter discards the pending change; non-zero pins become the baseline
    s0 = step_seen;
    a_in = ~m_ab[1];
    b_in = 1'b1;
    repeat (3) tick();
    do_reset();
    repeat (10) tick();
    check_state("mid_rst");
    checkOutput("mid_rst_steps", step_seen - s0, 0);

    // Velocity: 40 forward steps in window 0, 10 backward steps in window 1
    do_reset();
    for (int i = 0; i < 40; i++) step_by(1, 5);
    for (int k = 0; k < 1000 && edge_num < VEL_WIN + 4; k++) tick();
    for (int i = 0; i < 10; i++) step_by(-1, 5);
    for (int k = 0; k < 1000 && edge_num < 2 * VEL_WIN + 4; k++) tick();
    check_state("vel_run");
`ifdef QEI_VELOCITY_EN
    checkOutput("vel_w0", vel_log.exists(0) ? vel_log[0] : 32'hDEAD, 40);
    checkOutput("vel_w1", vel_log.exists(1) ? vel_log[1] : 32'hDEAD, 32'hFFF6);
    checkOutput("vel_pulses", vv_seen, 2);
`else
    checkOutput("vel_tied", 32'(vel), 0);
    checkOutput("vel_pulses", vv_seen, 0);
`endif

    // Random walk with glitches, illegal moves, index edges and error clears
    do_reset();
    for (int n = 0; n < 80; n++) begin
      r    = $urandom_range(0, 9);
      hold = $urandom_range(8, 14);
      nz   = ($urandom_range(0, 3) == 0) ? ~m_z : m_z;
      idx_clr_en = $urandom_range(0, 1) != 0;
      if (r <= 6 || r == 7) begin
        ab = ab_of(pos_of(m_ab) + ((r <= 3) ? 1 : (r <= 6) ? 3 : 2));
        applyStimulus(ab[1], ab[0], nz, hold);
      end else if (r == 8) begin
        len = $urandom_range(1, FILT_LEN - 1);
        if ($urandom_range(0, 1) != 0) a_in = ~a_in; else b_in = ~b_in;
        repeat (len) tick();
        a_in = m_ab[1];
        b_in = m_ab[0];
        repeat (10) tick();
      end else begin
        err_clr = 1'b1; tick(); err_clr = 1'b0; m_err = 1'b0;
        tick();
      end
      check_state("rand");
    end
    idx_clr_en = 1'b0;
    repeat (10) tick();
    checkOutput("total_steps", step_seen, m_steps);
    checkOutput("total_idx", idx_seen, m_idx);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qei_multi_counter.md
QEI_MULTI_COUNTER -- requirements
Module: qei_multi_counter

Interface
REQ-001 Parameter CNT_W, default 16: count width in bits, legal range 8..32.
REQ-002 Parameter SYNC_STAGES, default 2: synchronizer flop depth for each input pin, legal range 2..4.
REQ-003 Parameter FILT_LEN, default 4: number of consecutive equal synchronized samples needed to accept a new pin level, legal range 1..16.
REQ-004 Parameter VEL_WIN, default 1024: velocity window length in clk cycles, legal range 2..65535.
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 a_in  input  1  encoder channel A, asynchronous.
REQ-008 b_in  input  1  encoder channel B, asynchronous.
REQ-009 z_in  input  1  encoder index, asynchronous.
REQ-010 idx_clr_en  input  1  when 1, an accepted index rising edge clears the count.
REQ-011 err_clr  input  1  single-cycle clear of the sticky error flag.
REQ-012 count  output  CNT_W  position count, unsigned, wraps modulo 2^CNT_W.
REQ-013 dir  output  1  direction of the last legal step: 1 = forward, 0 = backward.
REQ-014 step  output  1  one-cycle pulse on every legal count change.
REQ-015 idx_pulse  output  1  one-cycle pulse on every accepted index rising edge.
REQ-016 err  output  1  sticky flag for an illegal transition.
REQ-017 vel  output  CNT_W  signed net step count of the last completed window.
REQ-018 vel_valid  output  1  one-cycle pulse when vel updates.

Function
REQ-019 Each of A, B and Z SHALL pass through its own SYNC_STAGES-deep synchronizer and then a FILT_LEN glitch filter.
REQ-020 The filtered level SHALL change only after the synchronized value has differed from it for FILT_LEN consecutive cycles; any shorter pulse SHALL be ignored.
REQ-021 Decoder state is {A,B} as filtered. The sequence 00->01->11->10->00 SHALL increment count by 1 and set dir=1.
REQ-022 The reverse sequence 00->10->11->01->00 SHALL decrement count by 1 and set dir=0.
REQ-023 count, dir and step SHALL update on the first clk edge after the filtered state changes.
REQ-024 Total latency from a pin change to the count change SHALL be exactly SYNC_STAGES+FILT_LEN+1 cycles (7 with defaults).
REQ-025 A transition in which both A and B change SHALL set err and leave count, dir and step unchanged; the decoder SHALL adopt the new state as its baseline.
REQ-026 err_clr=1 SHALL clear err; if a new illegal transition occurs in the same cycle, err SHALL stay 1.
REQ-027 Count wrap: all-ones plus one SHALL give 0, and 0 minus one SHALL give all-ones, with no flag.
REQ-028 A filtered Z rising edge SHALL pulse idx_pulse.
REQ-029 If idx_clr_en=1 at that edge, count SHALL become 0 on the same edge; a clear coinciding with a step SHALL yield 0, and step and dir SHALL still reflect the step.

Reset
REQ-030 While rst=1: count=0, dir=0, step=0, idx_pulse=0, err=0, vel=0, vel_valid=0, and all synchronizer, filter and window state cleared.
REQ-031 The first filtered {A,B} after reset release SHALL be adopted as baseline without counting or setting err, even when it is not 00.
REQ-032 rst asserted mid-window or mid-filter SHALL discard all partial state.

Configuration
REQ-033 The macro is QEI_VELOCITY_EN.
REQ-034 With QEI_VELOCITY_EN defined: a VEL_WIN-cycle free-running window SHALL accumulate net signed steps, with an index clear not affecting it.
REQ-035 With QEI_VELOCITY_EN defined, at window end: vel SHALL load the window total, vel_valid SHALL pulse once, and the accumulator SHALL restart from the step, if any, in that same cycle.
REQ-036 Without QEI_VELOCITY_EN: the ports SHALL remain present, vel SHALL be tied to 0, vel_valid SHALL be tied to 0, and no window logic SHALL be synthesized.

Verification
REQ-037 Reset, then AB 00->01->11->10->00 with 16 cycles per step -> count 0,1,2,3,4; dir=1 after each step; step pulses exactly 4 times.
REQ-038 From count=4, AB 00->10->11->01->00 -> count 3,2,1,0, dir=0; then one further backward step -> count=0xFFFF.
REQ-039 A high for 3 cycles with FILT_LEN=4 -> no count change and no step pulse; A high for 4 cycles -> count +1 exactly 7 cycles after the pin edge.
REQ-040 AB 00->11 -> err=1 and count unchanged; err_clr pulse -> err=0; 00->11 with err_clr asserted in the same cycle -> err=1.
REQ-041 count=0x0123, idx_clr_en=1, Z rising coinciding with a forward step -> count=0, idx_pulse=1, dir=1; with idx_clr_en=0 -> count=0x0124.
REQ-042 QEI_VELOCITY_EN, VEL_WIN=256: 40 forward steps within one window -> vel=40 with one vel_valid pulse; next window 10 backward steps -> vel=-10.
